// File: rtl/execute_divmod_ctrl.sv
// Execute-stage DIV/MOD controller with a restoring divider (one quotient bit per cycle).
// Latency WIDTH+1 cycles (1 for divide by zero); stalls Fetch/Decode/Execute until the result cycle.
module execute_divmod_ctrl #(
  parameter int WIDTH = 19,
  parameter int CNT_W = 5
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             ValidE,
  input  logic             FlushE,
  input  logic [2:0]       ALUControlE,
  input  logic [WIDTH-1:0] SrcAE,
  input  logic [WIDTH-1:0] SrcBE,
  output logic             StallDivE,
  output logic             DivDoneE,
  output logic [WIDTH-1:0] DivResultE,
  output logic             DivZeroE
);

  typedef enum logic [1:0] {S_IDLE, S_CALC, S_DONE} state_t;

  state_t           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [WIDTH-1:0] quo_q, quo_d;
  logic [WIDTH-1:0] rem_q, rem_d;
  logic [WIDTH-1:0] dvs_q, dvs_d;
  logic             mod_q, mod_d;
  logic             zero_q, zero_d;

  logic             is_divmod;
  logic             start;
  logic [WIDTH:0]   rem_sh;
  logic [WIDTH:0]   rem_diff;
  logic             rem_ge;

  assign is_divmod = (ALUControlE == 3'b011) || (ALUControlE == 3'b100);
  // Gating with reset keeps the stall low while reset is held.
  assign start     = reset & ValidE & ~FlushE & is_divmod;

  // One extra bit: the shifted remainder can reach 2*divisor-1.
  assign rem_sh    = {rem_q, quo_q[WIDTH-1]};
  assign rem_diff  = rem_sh - {1'b0, dvs_q};
  assign rem_ge    = (rem_sh >= {1'b0, dvs_q});

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    quo_d     = quo_q;
    rem_d     = rem_q;
    dvs_d     = dvs_q;
    mod_d     = mod_q;
    zero_d    = zero_q;
    StallDivE = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (start) begin
          StallDivE = 1'b1;
          mod_d     = (ALUControlE == 3'b100);
          if (SrcBE != '0) begin
            quo_d   = SrcAE;
            rem_d   = '0;
            dvs_d   = SrcBE;
            cnt_d   = CNT_W'(WIDTH);
            zero_d  = 1'b0;
            state_d = S_CALC;
          end else begin
            quo_d   = '1;
            rem_d   = SrcAE;
            zero_d  = 1'b1;
            state_d = S_DONE;
          end
        end
      end
      S_CALC: begin
        StallDivE = 1'b1;
        if (FlushE) begin
          state_d = S_IDLE;
        end else begin
          rem_d = rem_ge ? rem_diff[WIDTH-1:0] : rem_sh[WIDTH-1:0];
          quo_d = {quo_q[WIDTH-2:0], rem_ge};
          cnt_d = cnt_q - CNT_W'(1);
          if (cnt_q == CNT_W'(1)) state_d = S_DONE;
        end
      end
      S_DONE: begin
        state_d = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
      quo_q   <= '0;
      rem_q   <= '0;
      dvs_q   <= '0;
      mod_q   <= 1'b0;
      zero_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      quo_q   <= quo_d;
      rem_q   <= rem_d;
      dvs_q   <= dvs_d;
      mod_q   <= mod_d;
      zero_q  <= zero_d;
    end
  end

  assign DivDoneE   = (state_q == S_DONE);
  assign DivResultE = mod_q ? rem_q : quo_q;
  assign DivZeroE   = zero_q;

endmodule

// File: doc/execute_divmod_ctrl.md
Name: execute_divmod_ctrl

Overview:
- Multi-cycle controller and iterative datapath for the Execute-stage DIV (ALUControlE=3'b011) and MOD (3'b100) operations of the 19-bit core.
- Detects a DIV/MOD in Execute and stalls the front of the pipeline while it runs a restoring division, one quotient bit per cycle.
- Presents the quotient or remainder to the ALU result mux for one cycle, then releases the stall.
- All other ALU operations pass through without stalls.

Parameters:
WIDTH, 19, operand/result width in bits
CNT_W, 5, iteration counter width; must satisfy 2^CNT_W > WIDTH

Ports:
clk  input  1  system clock, rising edge
reset  input  1  asynchronous, active-low reset
ValidE  input  1  Execute stage holds a real (non-bubble) instruction
FlushE  input  1  Execute stage is being flushed this cycle
ALUControlE  input  3  ALU operation of the instruction in Execute
SrcAE  input  WIDTH  dividend (RD1E path)
SrcBE  input  WIDTH  divisor (RD2E or ImmExtE after ALUSrcE mux)
StallDivE  output  1  hold the Fetch, Decode and Execute registers this cycle
DivDoneE  output  1  DivResultE is valid this cycle
DivResultE  output  WIDTH  quotient (DIV) or remainder (MOD)
DivZeroE  output  1  divisor was zero; qualified by DivDoneE

Behaviour:
- Reset (reset=0, asynchronous):
  - state=IDLE; counter, operand and result registers cleared.
  - StallDivE=0, DivDoneE=0, DivResultE=0, DivZeroE=0.
- Arithmetic: unsigned only. Quotient Q, remainder R with SrcAE = Q*SrcBE + R and R < SrcBE.
- start = ValidE & ~FlushE & (ALUControlE==3'b011 | ALUControlE==3'b100), evaluated in IDLE only.
- IDLE:
  - start=1 and SrcBE!=0: latch dividend, divisor and op (DIV/MOD); clear the partial remainder; counter=WIDTH; go to CALC.
  - start=1 and SrcBE==0: latch dividend and op; go to DONE with the zero flag set.
  - Otherwise remain in IDLE.
- CALC: each cycle performs one restoring step.
  - Shift {rem, quo} left by 1, bringing in the next dividend bit.
  - If rem >= divisor: subtract the divisor and set the quotient LSB.
  - Decrement the counter. The step that takes the counter from 1 to 0 transitions to DONE.
- DONE (exactly one cycle), then unconditionally IDLE:
  - DivDoneE=1.
  - DivResultE = quotient for DIV, remainder for MOD.
  - Divide by zero: quotient=all-ones (19'h7FFFF), remainder=dividend, DivZeroE=1.
- StallDivE (combinational):
  - StallDivE = (state==IDLE & start) | (state==CALC).
  - Low in DONE, so the stalled instruction advances to Memory on the clock edge closing DONE, carrying DivResultE.
- Latency, with T0 = cycle the instruction first appears in Execute:
  - Normal: StallDivE high T0..T19 (20 cycles); DONE at T20.
  - Divide by zero: StallDivE high at T0 only; DONE at T1.
- DivResultE and DivZeroE hold their value outside DONE. Only the DivDoneE=1 cycle is meaningful.
- Flush:
  - FlushE=1 in CALC aborts to IDLE on the next edge: no DivDoneE, registers unchanged, StallDivE drops the following cycle.
  - FlushE=1 in DONE is ignored; the result is discarded downstream.
- Back-to-back DIV/MOD: the cycle after DONE is IDLE with the next instruction in Execute. A new start is accepted then; the same instruction is never restarted, because it left Execute at the DONE edge.
- Inputs SrcAE and SrcBE are don't-care outside the IDLE start cycle.
- Asserting reset mid-CALC returns to IDLE immediately, with all outputs at their reset values.

Test Plan:
- DIV 20/10 (SrcAE=20, SrcBE=10, ALUControlE=011, ValidE=1) -> StallDivE high 20 cycles; at T20 DivDoneE=1, DivResultE=2, DivZeroE=0.
- MOD 29%5 (ALUControlE=100) -> at T20 DivResultE=4. Then, back-to-back, DIV 524287/1 -> next DONE gives DivResultE=524287 with no idle gap beyond the 1-cycle DONE/IDLE boundary.
- Divide by zero: DIV 15/0 -> StallDivE high only at T0; at T1 DivDoneE=1, DivResultE=19'h7FFFF, DivZeroE=1. MOD 15/0 -> DivResultE=15, DivZeroE=1.
- Non-divide ops (ALUControlE=000, 001, 010, e.g. 15*2) -> StallDivE=0 and DivDoneE=0 on every cycle.
- Flush mid-operation: DIV 100/7 started, FlushE=1 at T5 -> StallDivE=0 from T6, no DivDoneE pulse. A following MOD 100/7 then completes 20 cycles later with DivResultE=2.
- Reset mid-operation: reset=0 at T8 of DIV 20/10 -> outputs 0 immediately; after release, state is IDLE and ValidE=0 yields no stall.
